// File: rtl/universal_reg.sv
// Multi-mode WIDTH-bit register: hold, parallel load, shift, rotate and up/down count,
// with zero flag and a registered one-cycle overflow/underflow pulse.
`timescale 1ns/1ps
module universal_reg #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               SATURATE  = 1'b0
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             EN,
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SIN,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_bar,
  output logic             SOUT,
  output logic             ZERO,
  output logic             OVF
);

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_LOAD = 3'b001,
    M_SHL  = 3'b010,
    M_SHR  = 3'b011,
    M_ROL  = 3'b100,
    M_ROR  = 3'b101,
    M_INC  = 3'b110,
    M_DEC  = 3'b111
  } mode_e;

  logic [WIDTH-1:0] r_q;
  logic             r_ovf;
  logic [WIDTH-1:0] w_next;
  logic             w_ovf_hit;
  logic             w_ones;
  logic             w_zero;
  mode_e            w_mode;

  assign w_mode = mode_e'(MODE);
  assign w_ones = &r_q;
  assign w_zero = ~|r_q;

  always_comb begin
    w_next    = r_q;
    w_ovf_hit = 1'b0;
    case (w_mode)
      M_HOLD: w_next = r_q;
      M_LOAD: w_next = D;
      M_SHL:  w_next = {r_q[WIDTH-2:0], SIN};
      M_SHR:  w_next = {SIN, r_q[WIDTH-1:1]};
      M_ROL:  w_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
      M_ROR:  w_next = {r_q[0], r_q[WIDTH-1:1]};
      M_INC: begin
        // The boundary pulse is the same whether the count wraps or clamps.
        w_ovf_hit = w_ones;
        if (w_ones && SATURATE) w_next = r_q;
        else                    w_next = r_q + WIDTH'(1);
      end
      M_DEC: begin
        w_ovf_hit = w_zero;
        if (w_zero && SATURATE) w_next = r_q;
        else                    w_next = r_q - WIDTH'(1);
      end
      default: w_next = r_q;
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_q   <= RESET_VAL;
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= EN & w_ovf_hit;
      if (EN) r_q <= w_next;
    end
  end

  always_comb begin
    SOUT = 1'b0;
    case (w_mode)
      M_SHL:   SOUT = r_q[WIDTH-1];
      M_SHR:   SOUT = r_q[0];
      default: SOUT = 1'b0;
    endcase
  end

  assign Q     = r_q;
  assign Q_bar = ~r_q;
  assign ZERO  = w_zero;
  assign OVF   = r_ovf;

endmodule

// File: tb/tb_universal_reg.sv
// Scoreboard bench for universal_reg: three instances (wrapping, saturating, non-zero reset value)
// driven by directed steps; a monitor pops expected states and compares them to the outputs.
`timescale 1ns/1ps
module tb_universal_reg;

  localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, SHL = 3'b010, SHR = 3'b011,
                         ROL  = 3'b100, ROR  = 3'b101, INC = 3'b110, DEC = 3'b111;

  logic       clk;
  logic       clr_i  [3];
  logic       en_i   [3];
  logic [2:0] mode_i [3];
  logic [7:0] d_i    [3];
  logic       sin_i  [3];
  logic [7:0] q_o    [3];
  logic [7:0] qb_o   [3];
  logic       sout_o [3];
  logic       zero_o [3];
  logic       ovf_o  [3];

  universal_reg #(.WIDTH(8), .RESET_VAL(8'h00), .SATURATE(1'b0)) u_wrap (
    .CLK(clk), .CLR(clr_i[0]), .EN(en_i[0]), .MODE(mode_i[0]), .D(d_i[0]), .SIN(sin_i[0]),
    .Q(q_o[0]), .Q_bar(qb_o[0]), .SOUT(sout_o[0]), .ZERO(zero_o[0]), .OVF(ovf_o[0]));

  universal_reg #(.WIDTH(8), .RESET_VAL(8'h00), .SATURATE(1'b1)) u_sat (
    .CLK(clk), .CLR(clr_i[1]), .EN(en_i[1]), .MODE(mode_i[1]), .D(d_i[1]), .SIN(sin_i[1]),
    .Q(q_o[1]), .Q_bar(qb_o[1]), .SOUT(sout_o[1]), .ZERO(zero_o[1]), .OVF(ovf_o[1]));

  universal_reg #(.WIDTH(8), .RESET_VAL(8'h5A), .SATURATE(1'b0)) u_rv (
    .CLK(clk), .CLR(clr_i[2]), .EN(en_i[2]), .MODE(mode_i[2]), .D(d_i[2]), .SIN(sin_i[2]),
    .Q(q_o[2]), .Q_bar(qb_o[2]), .SOUT(sout_o[2]), .ZERO(zero_o[2]), .OVF(ovf_o[2]));

  typedef struct {
    int         cyc;
    int         ph;
    int         u;
    logic [7:0] q;
    logic       ovf;
    logic       chk_sout;
    logic       sout;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   stepno = 0;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input int ph, input int u, input logic [7:0] q,
                      input logic ovf, input logic chk_sout, input logic sout, input string nm);
    exp_t e;
    e.cyc = c; e.ph = ph; e.u = u; e.q = q; e.ovf = ovf;
    e.chk_sout = chk_sout; e.sout = sout; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  task automatic drain(input int ph);
    exp_t e;
    while (sb.size() > 0 &&
           (sb[0].cyc < cyc || (sb[0].cyc == cyc && sb[0].ph <= ph))) begin
      e = sb.pop_front();
      if (e.cyc != cyc || e.ph != ph) begin
        checks++;
        errors++;
        $display("FAIL %s: entry missed its sample slot (cyc %0d ph %0d, now %0d)",
                 e.nm, e.cyc, e.ph, cyc);
      end else begin
        cmp({e.nm, " Q"},     q_o[e.u],            e.q);
        cmp({e.nm, " OVF"},   {7'd0, ovf_o[e.u]},  {7'd0, e.ovf});
        cmp({e.nm, " ZERO"},  {7'd0, zero_o[e.u]}, {7'd0, (e.q == 8'h00)});
        cmp({e.nm, " Q_bar"}, qb_o[e.u],           ~e.q);
        if (e.chk_sout) cmp({e.nm, " SOUT"}, {7'd0, sout_o[e.u]}, {7'd0, e.sout});
      end
    end
  endtask

  // Phase 0 samples 2ns after the falling edge, phase 1 at 4ns (inside a CLR pulse).
  initial begin
    forever begin
      @(negedge clk);
      #2 drain(0);
      #2 drain(1);
    end
  end

  // One clock step: drive inputs on the falling edge, expect pre_* before the rising edge,
  // optionally pulse CLR mid-cycle (expect clr_q, OVF=0), then expect post_* after the edge.
  task automatic step(input int u, input logic en, input logic [2:0] mode, input logic [7:0] d,
                      input logic sin, input logic clrp,
                      input logic [7:0] pre_q, input logic pre_ovf, input logic pre_sout,
                      input logic [7:0] clr_q, input logic [7:0] post_q, input logic post_ovf);
    int c;
    @(negedge clk);
    c = cyc;
    stepno++;
    en_i[u] = en; mode_i[u] = mode; d_i[u] = d; sin_i[u] = sin;
    push(c, 0, u, pre_q, pre_ovf, 1'b1, pre_sout, $sformatf("u%0d s%0d pre", u, stepno));
    if (clrp) push(c, 1, u, clr_q, 1'b0, 1'b0, 1'b0, $sformatf("u%0d s%0d clr", u, stepno));
    push(c + 1, 0, u, post_q, post_ovf, 1'b0, 1'b0, $sformatf("u%0d s%0d post", u, stepno));
    if (clrp) begin
      #3 clr_i[u] = 1'b1;
      #3 clr_i[u] = 1'b0;
    end
  endtask

  initial begin
    int guard;
    for (int i = 0; i < 3; i++) begin
      clr_i[i] = 1'b1; en_i[i] = 1'b0; mode_i[i] = HOLD; d_i[i] = 8'h00; sin_i[i] = 1'b0;
    end
    #3;
    for (int i = 0; i < 3; i++) clr_i[i] = 1'b0;

    //   u  en    mode  d      sin   clr   preQ   pOVF  pSOUT clrQ   postQ  postOVF
    step(0, 1'b1, LOAD, 8'h12, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h12, 1'b0);
    step(0, 1'b1, LOAD, 8'hA5, 1'b0, 1'b1, 8'h12, 1'b0, 1'b0, 8'h00, 8'hA5, 1'b0);
    step(0, 1'b1, LOAD, 8'h81, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h81, 1'b0);
    step(0, 1'b1, SHL,  8'h00, 1'b1, 1'b0, 8'h81, 1'b0, 1'b1, 8'h00, 8'h03, 1'b0);
    step(0, 1'b1, SHR,  8'h00, 1'b0, 1'b0, 8'h03, 1'b0, 1'b1, 8'h00, 8'h01, 1'b0);
    step(0, 1'b1, LOAD, 8'h81, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 8'h00, 8'h81, 1'b0);
    step(0, 1'b1, ROL,  8'h00, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0, 8'h00, 8'h03, 1'b0);
    step(0, 1'b1, ROR,  8'h00, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 8'h00, 8'h81, 1'b0);
    step(0, 1'b1, ROR,  8'h00, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0, 8'h00, 8'hC0, 1'b0);
    step(0, 1'b0, ROR,  8'h00, 1'b0, 1'b0, 8'hC0, 1'b0, 1'b0, 8'h00, 8'hC0, 1'b0);
    step(0, 1'b1, LOAD, 8'hFF, 1'b0, 1'b0, 8'hC0, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b0);
    step(0, 1'b1, INC,  8'h00, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    step(0, 1'b1, HOLD, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    step(0, 1'b1, DEC,  8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b1);
    step(0, 1'b0, DEC,  8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b0);
    step(0, 1'b1, LOAD, 8'h7F, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h7F, 1'b0);
    step(0, 1'b1, INC,  8'h00, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0, 8'h00, 8'h80, 1'b0);
    step(0, 1'b1, SHL,  8'h00, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
    step(0, 1'b0, HOLD, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    step(1, 1'b1, LOAD, 8'hFE, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'hFE, 1'b0);
    step(1, 1'b1, INC,  8'h00, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b0);
    step(1, 1'b1, INC,  8'h00, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b1);
    step(1, 1'b1, INC,  8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b1);
    step(1, 1'b1, LOAD, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    step(1, 1'b1, DEC,  8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    step(1, 1'b1, DEC,  8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
    step(1, 1'b1, INC,  8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h01, 1'b0);
    step(1, 1'b0, HOLD, 8'h00, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0);

    step(2, 1'b1, INC,  8'h00, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 8'h5A, 8'h5B, 1'b0);
    step(2, 1'b1, INC,  8'h00, 1'b0, 1'b0, 8'h5B, 1'b0, 1'b0, 8'h5A, 8'h5C, 1'b0);
    step(2, 1'b1, INC,  8'h00, 1'b0, 1'b1, 8'h5C, 1'b0, 1'b0, 8'h5A, 8'h5B, 1'b0);
    step(2, 1'b1, LOAD, 8'hFF, 1'b0, 1'b0, 8'h5B, 1'b0, 1'b0, 8'h5A, 8'hFF, 1'b0);
    step(2, 1'b1, INC,  8'h00, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 8'h5A, 8'h00, 1'b1);
    step(2, 1'b1, INC,  8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h5A, 8'h5B, 1'b0);
    step(2, 1'b0, INC,  8'h00, 1'b0, 1'b0, 8'h5B, 1'b0, 1'b0, 8'h5A, 8'h5B, 1'b0);

    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    #6;
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected entries never sampled, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
